// File: rtl/eth_rx_pkg.sv
// Shared types, constants and the byte-parallel CRC-32 step for the Ethernet receive path.
package eth_rx_pkg;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} rxState_t;

  localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  SFD_LAST_DIBIT = 2'b11;
  localparam logic [31:0] CRC_POLY       = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT       = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB20E3;

  // Bit positions inside err_flags = {rxer, align, len, crc}.
  localparam int ERR_CRC   = 0;
  localparam int ERR_LEN   = 1;
  localparam int ERR_ALIGN = 2;
  localparam int ERR_RXER  = 3;

  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Registered reflected CRC-32, one byte per enabled cycle; also used by the transmit FCS generator.
module eth_crc32_d8
  import eth_rx_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_crc <= CRC_INIT;
    end else if (i_init) begin
      r_crc <= CRC_INIT;
    end else if (i_en) begin
      r_crc <= crc32_d8(r_crc, i_data);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/rmii_frame_receiver.sv
// RMII receive path: strips preamble/SFD, assembles bytes, checks FCS, length and alignment,
// and reports one status strobe per frame.
module rmii_frame_receiver
  import eth_rx_pkg::*;
#(
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int MIN_FRAME_BYTES = 64
) (
  input  logic        i_clk_50_mhz,
  input  logic        i_rst_n,
  input  logic [1:0]  i_rx_d,
  input  logic        i_crs_dv,
  input  logic        i_rx_er,
  output logic [7:0]  o_data,
  output logic        o_data_valid,
  output logic        o_sof,
  output logic        o_eof,
  output logic        o_frame_ok,
  output logic [3:0]  o_err_flags,
  output logic [10:0] o_frame_len,
  output logic        o_busy,
  output logic [15:0] o_good_frame_cnt
);

  localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_BYTES);
  localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_BYTES);

  rxState_t    r_state, w_nextState;
  logic [5:0]  r_shift;
  logic [1:0]  r_dibitCnt;
  logic [10:0] r_byteCnt;
  logic        r_rxerSeen, r_lenOverflow, r_report, r_sofPending;
  logic [31:0] w_crc;

  logic [7:0]  w_byte;
  logic        w_sfd, w_dataDibit, w_byteDone, w_overflow, w_emit;
  logic        w_endFrame, w_rxerNow, w_goodFrame;
  logic [3:0]  w_endFlags;

  eth_crc32_d8 u_crc (
    .i_clk   (i_clk_50_mhz),
    .i_rst_n (i_rst_n),
    .i_init  (w_sfd),
    .i_en    (w_emit),
    .i_data  (w_byte),
    .o_crc   (w_crc)
  );

  always_ff @(posedge i_clk_50_mhz) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The first low crs_dv sample always wins; PHY carrier toggling is not tracked.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (i_crs_dv) begin
          w_nextState = (i_rx_d == PREAMBLE_DIBIT) ? PREAMBLE : DROP;
        end
      end
      PREAMBLE: begin
        if (!i_crs_dv) begin
          w_nextState = IDLE;
        end else if (i_rx_d == SFD_LAST_DIBIT) begin
          w_nextState = DATA;
        end else if (i_rx_d != PREAMBLE_DIBIT) begin
          w_nextState = DROP;
        end
      end
      DATA: begin
        if (!i_crs_dv) begin
          w_nextState = IDLE;
        end else if (w_overflow) begin
          w_nextState = DROP;
        end
      end
      DROP: begin
        if (!i_crs_dv) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_byte      = {i_rx_d, r_shift};
    w_sfd       = (r_state == PREAMBLE) && i_crs_dv && (i_rx_d == SFD_LAST_DIBIT);
    w_dataDibit = (r_state == DATA) && i_crs_dv;
    w_byteDone  = w_dataDibit && (r_dibitCnt == 2'd3);
    w_overflow  = w_byteDone && (r_byteCnt >= MAX_LEN);
    w_emit      = w_byteDone && !w_overflow;
    w_rxerNow   = (r_state == DATA) && i_rx_er;
    w_endFrame  = !i_crs_dv && ((r_state == DATA) || ((r_state == DROP) && r_report));
    w_endFlags            = 4'd0;
    w_endFlags[ERR_CRC]   = (w_crc != CRC_RESIDUE);
    w_endFlags[ERR_LEN]   = r_lenOverflow || (r_byteCnt < MIN_LEN);
    w_endFlags[ERR_ALIGN] = (r_dibitCnt != 2'd0);
    w_endFlags[ERR_RXER]  = r_rxerSeen || w_rxerNow;
    w_goodFrame = w_endFrame && (w_endFlags == 4'd0);
  end

  always_ff @(posedge i_clk_50_mhz) begin
    if (!i_rst_n) begin
      o_data           <= 8'd0;
      o_data_valid     <= 1'b0;
      o_sof            <= 1'b0;
      o_eof            <= 1'b0;
      o_frame_ok       <= 1'b0;
      o_err_flags      <= 4'd0;
      o_frame_len      <= 11'd0;
      o_good_frame_cnt <= 16'd0;
      r_shift          <= 6'd0;
      r_dibitCnt       <= 2'd0;
      r_byteCnt        <= 11'd0;
      r_rxerSeen       <= 1'b0;
      r_lenOverflow    <= 1'b0;
      r_report         <= 1'b0;
      r_sofPending     <= 1'b0;
    end else begin
      o_data_valid <= w_emit;
      o_sof        <= w_emit && r_sofPending;
      o_eof        <= w_endFrame;
      if (w_emit) begin
        o_data <= w_byte;
      end
      if (w_endFrame) begin
        o_err_flags <= w_endFlags;
        o_frame_ok  <= (w_endFlags == 4'd0);
        o_frame_len <= r_byteCnt;
        r_report    <= 1'b0;
      end
      if (w_goodFrame) begin
        o_good_frame_cnt <= o_good_frame_cnt + 16'd1;
      end

      if (w_sfd) begin
        r_dibitCnt    <= 2'd0;
        r_byteCnt     <= 11'd0;
        r_rxerSeen    <= 1'b0;
        r_lenOverflow <= 1'b0;
        r_report      <= 1'b0;
        r_sofPending  <= 1'b1;
      end else if (w_dataDibit) begin
        r_shift    <= {i_rx_d, r_shift[5:2]};
        r_dibitCnt <= r_dibitCnt + 2'd1;
        if (w_byteDone && (r_byteCnt != 11'h7FF)) begin
          r_byteCnt <= r_byteCnt + 11'd1;
        end
        if (w_emit) begin
          r_sofPending <= 1'b0;
        end
        if (w_rxerNow) begin
          r_rxerSeen <= 1'b1;
        end
        // Oversized frames keep their status so the DROP exit can report them.
        if (w_overflow) begin
          r_lenOverflow <= 1'b1;
          r_report      <= 1'b1;
        end
      end
    end
  end

  assign o_busy = (r_state != IDLE);

endmodule

// File: tb/tb_rmii_frame_receiver.sv
// Scoreboard bench for rmii_frame_receiver: frames are built byte-wise with a reference FCS,
// expected bytes/status are queued at issue time and a monitor compares whatever the DUT emits.
module tb_rmii_frame_receiver;

  localparam int MAX_BYTES = 1518;
  localparam int MIN_BYTES = 64;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [1:0]  rxD = 2'b00;
  logic        crsDv = 1'b0;
  logic        rxEr = 1'b0;
  logic [7:0]  data;
  logic        dataValid, sof, eof, frameOk, busy;
  logic [3:0]  errFlags;
  logic [10:0] frameLen;
  logic [15:0] goodCnt;

  typedef struct packed {logic sof; logic [7:0] data;} ExpByte;
  typedef struct packed {logic [3:0] flags; logic [10:0] len; logic [15:0] cnt;} ExpStatus;

  ExpByte      byteQ[$];
  ExpStatus    statusQ[$];
  logic [7:0]  frm[$];
  logic [1:0]  dib[$];
  int          total = 0;
  int          bad = 0;
  int          goodModel = 0;
  bit          done = 0;
  ExpByte      eb;
  ExpStatus    es;

  rmii_frame_receiver #(.MAX_FRAME_BYTES(MAX_BYTES), .MIN_FRAME_BYTES(MIN_BYTES)) dut (
    .i_clk_50_mhz     (clk),
    .i_rst_n          (rstN),
    .i_rx_d           (rxD),
    .i_crs_dv         (crsDv),
    .i_rx_er          (rxEr),
    .o_data           (data),
    .o_data_valid     (dataValid),
    .o_sof            (sof),
    .o_eof            (eof),
    .o_frame_ok       (frameOk),
    .o_err_flags      (errFlags),
    .o_frame_len      (frameLen),
    .o_busy           (busy),
    .o_good_frame_cnt (goodCnt)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-serial CRC-32 over the first n bytes of frm.
  function automatic logic [31:0] crcOver(input int n);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ frm[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  task automatic applyStimulus(input int payloadLen, input bit randomPayload, input bit corrupt,
                               input int extraDibits, input bit withRxer, input int resetByte,
                               input bit badPreamble);
    logic [31:0] fcs;
    logic [7:0]  b;
    logic [3:0]  flags;
    int          nBytes, counted, rxerIdx, resetDibit, ifg;
    frm.delete();
    dib.delete();
    for (int i = 0; i < payloadLen; i++) begin
      frm.push_back(randomPayload ? 8'($urandom) : 8'(i));
    end
    fcs = ~crcOver(payloadLen);
    for (int i = 0; i < 4; i++) begin
      frm.push_back(fcs[7:0]);
      fcs = fcs >> 8;
    end
    if (corrupt) frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h80;
    nBytes = frm.size();

    for (int i = 0; i < 31; i++) dib.push_back(2'b01);
    dib.push_back(2'b11);
    if (badPreamble) dib[29] = 2'b10;
    for (int i = 0; i < nBytes; i++) begin
      b = frm[i];
      dib.push_back(b[1:0]);
      dib.push_back(b[3:2]);
      dib.push_back(b[5:4]);
      dib.push_back(b[7:6]);
    end
    for (int i = 0; i < extraDibits; i++) dib.push_back(2'($urandom));

    rxerIdx    = withRxer ? $urandom_range(32, 32 + 4*nBytes - 1) : -1;
    resetDibit = (resetByte >= 0) ? 32 + 4*resetByte : -1;

    if (resetByte >= 0) begin
      for (int i = 0; i < resetByte; i++) byteQ.push_back('{sof: (i == 0), data: frm[i]});
    end else if (!badPreamble) begin
      counted = (nBytes > MAX_BYTES) ? MAX_BYTES : nBytes;
      for (int i = 0; i < counted; i++) byteQ.push_back('{sof: (i == 0), data: frm[i]});
      flags    = 4'd0;
      flags[0] = (crcOver(counted) != 32'hDEBB20E3);
      flags[1] = (nBytes < MIN_BYTES) || (nBytes > MAX_BYTES);
      flags[2] = (nBytes <= MAX_BYTES) && (extraDibits != 0);
      flags[3] = withRxer;
      if (flags == 4'd0) goodModel++;
      statusQ.push_back('{flags: flags,
                          len: 11'((nBytes > MAX_BYTES) ? MAX_BYTES + 1 : nBytes),
                          cnt: 16'(goodModel)});
    end

    for (int i = 0; i < dib.size(); i++) begin
      @(negedge clk);
      if (resetDibit >= 0 && i == resetDibit + 2) begin
        checkOutput("resetMidFrame",
                    64'({data, dataValid, sof, eof, frameOk, errFlags, frameLen, busy, goodCnt}), 64'd0);
      end
      if (badPreamble && i == dib.size() - 1) checkOutput("busyInDrop", 64'(busy), 64'd1);
      rxD   = dib[i];
      crsDv = 1'b1;
      rxEr  = (i == rxerIdx);
      rstN  = !(resetDibit >= 0 && (i == resetDibit || i == resetDibit + 1));
      if (resetDibit >= 0 && i == resetDibit) goodModel = 0;
    end
    @(negedge clk);
    crsDv = 1'b0;
    rxD   = 2'b00;
    rxEr  = 1'b0;
    rstN  = 1'b1;
    ifg = $urandom_range(1, 4);
    for (int i = 0; i < ifg; i++) begin
      @(negedge clk);
      if (badPreamble && i == 0) checkOutput("busyAfterDrop", 64'(busy), 64'd0);
    end
  endtask

  always @(negedge clk) begin
    if (dataValid || eof) begin
      checkOutput("validEofExclusive", 64'(dataValid && eof), 64'd0);
    end
    if (dataValid) begin
      if (byteQ.size() == 0) begin
        checkOutput("unexpectedByte", 64'({sof, data}), 64'h1FF);
      end else begin
        eb = byteQ.pop_front();
        checkOutput("byte", 64'({sof, data}), 64'({eb.sof, eb.data}));
      end
    end
    if (eof) begin
      if (statusQ.size() == 0) begin
        checkOutput("unexpectedEof", 64'({frameOk, errFlags, frameLen}), 64'hFFFF);
      end else begin
        es = statusQ.pop_front();
        checkOutput("eofStatus", 64'({frameOk, errFlags, frameLen, goodCnt}),
                    64'({(es.flags == 4'd0), es.flags, es.len, es.cnt}));
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("resetState",
                64'({data, dataValid, sof, eof, frameOk, errFlags, frameLen, busy, goodCnt}), 64'd0);
    rstN = 1'b1;
    repeat (3) @(negedge clk);

    applyStimulus(60, 0, 0, 0, 0, -1, 0);
    applyStimulus(60, 0, 1, 0, 0, -1, 0);
    applyStimulus(36, 0, 0, 0, 0, -1, 0);
    applyStimulus(60, 0, 0, 1, 0, -1, 0);
    applyStimulus(60, 1, 0, 0, 1, -1, 0);
    applyStimulus(60, 0, 0, 0, 0, -1, 1);
    applyStimulus(60, 0, 0, 0, 0, 20, 0);
    applyStimulus(60, 1, 0, 0, 0, -1, 0);
    checkOutput("goodCntAfterReset", 64'(goodCnt), 64'd1);

    for (int f = 0; f < 12; f++) begin
      applyStimulus($urandom_range(40, 120), 1, ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                    ($urandom_range(0, 3) == 0), -1, 0);
    end

    applyStimulus(MAX_BYTES - 4, 1, 0, 0, 0, -1, 0);
    applyStimulus(MAX_BYTES - 3, 1, 0, 0, 0, -1, 0);
    applyStimulus(MIN_BYTES - 5, 1, 0, 0, 0, -1, 0);

    repeat (20) @(negedge clk);
    checkOutput("byteQueueDrained", 64'(byteQ.size()), 64'd0);
    checkOutput("statusQueueDrained", 64'(statusQ.size()), 64'd0);
    done = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    if (!done) begin
      bad++;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
    end
  end

endmodule
